// File: rtl/noc_pkg.sv
// noc_pkg
// Shared definitions for the spike injection path into the router local port.
//   DEFAULT_FLIT_SIZE   : default router flit width in bits
//   DEFAULT_PACKET_SIZE : default spike packet width in bits
//   ser_state_t         : serializer state (IDLE waiting for a packet, SEND streaming flits)
package noc_pkg;

    localparam int DEFAULT_FLIT_SIZE   = 4;
    localparam int DEFAULT_PACKET_SIZE = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/spike_fifo.sv
// spike_fifo
// Synchronous packet FIFO. Push and pop may happen in the same cycle at any
// occupancy: at full the pop frees the slot the push uses, at empty the pushed
// entry only becomes visible at the head on the following cycle.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   push, push_data     : write request and data
//   pop, pop_data       : read request and current head entry
//   full, empty, count  : occupancy flags and number of stored entries
module spike_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot a push at full would need.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/spike_inject_port.sv
// spike_inject_port
// Local-port injector: captures single-cycle spike packets from NUM_SRC neurons
// into per-source holding registers, arbitrates them round-robin into a packet
// FIFO and serialises each packet MSB-first into FLIT_SIZE-wide flits for the
// router under full-flag backpressure. Spikes that find their holder occupied
// are dropped and counted.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   spike_valid   : per-source spike strobe
//   spike_packet  : per-source packet, source i at [i*PACKET_SIZE +: PACKET_SIZE]
//   router_full   : router cannot accept a flit this cycle
//   flit_out      : current flit
//   write_req     : flit_out valid
//   busy          : serializer is streaming a packet
//   fifo_count    : packets queued in the FIFO
//   src_pending   : per-source holding register occupied
//   drop_count    : saturating count of dropped spikes
module spike_inject_port
    import noc_pkg::*;
#(
    parameter int NUM_SRC        = 2,
    parameter int PACKET_SIZE    = DEFAULT_PACKET_SIZE,
    parameter int FLIT_SIZE      = DEFAULT_FLIT_SIZE,
    parameter int FIFO_DEPTH     = 4,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SRC-1:0]             spike_valid,
    input  logic [NUM_SRC*PACKET_SIZE-1:0] spike_packet,
    input  logic                           router_full,
    output logic [FLIT_SIZE-1:0]           flit_out,
    output logic                           write_req,
    output logic                           busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic [NUM_SRC-1:0]             src_pending,
    output logic [DROP_CNT_WIDTH-1:0]      drop_count
);

    localparam int FLITS = PACKET_SIZE / FLIT_SIZE;
    localparam int IDX_W = (FLITS > 1) ? $clog2(FLITS) : 1;
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PACKET_SIZE-1:0]    hold_packet [NUM_SRC];
    logic [PTR_W-1:0]          rr_ptr;
    logic [PTR_W-1:0]          cand;
    logic [PTR_W-1:0]          grant_idx;
    logic                      grant_valid;
    logic [NUM_SRC-1:0]        grant_vec;
    logic [NUM_SRC-1:0]        load_vec;
    logic [NUM_SRC-1:0]        drop_vec;
    logic [DROP_CNT_WIDTH-1:0] drop_next;
    logic [PACKET_SIZE-1:0]    grant_packet;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_pop;
    logic [PACKET_SIZE-1:0]    fifo_head;

    ser_state_t                state;
    ser_state_t                state_next;
    logic [PACKET_SIZE-1:0]    shift_reg;
    logic [IDX_W-1:0]          flit_idx;
    logic                      xfer;
    logic                      last_flit;

    // Round-robin arbiter: first pending source at or after rr_ptr, and only
    // while the FIFO has room.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_SRC);
            if (!fifo_full && !grant_valid && src_pending[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_packet = hold_packet[grant_idx];

    // A holder accepts a new spike when empty or when it is emptied by this
    // cycle's grant; anything else is a drop.
    always_comb begin
        grant_vec = '0;
        if (grant_valid) begin
            grant_vec[grant_idx] = 1'b1;
        end
        load_vec = spike_valid & (~src_pending | grant_vec);
        drop_vec = spike_valid & ~load_vec;
    end

    always_comb begin
        drop_next = drop_count;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (drop_vec[i] && (drop_next != '1)) begin
                drop_next = drop_next + DROP_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_pending <= '0;
            drop_count  <= '0;
            rr_ptr      <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (load_vec[i]) begin
                    src_pending[i] <= 1'b1;
                end else if (grant_vec[i]) begin
                    src_pending[i] <= 1'b0;
                end
            end
            drop_count <= drop_next;
            if (grant_valid) begin
                rr_ptr <= (int'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (load_vec[i]) begin
                hold_packet[i] <= spike_packet[i*PACKET_SIZE +: PACKET_SIZE];
            end
        end
    end

    spike_fifo #(
        .WIDTH (PACKET_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (grant_valid),
        .push_data (grant_packet),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign xfer      = (state == SEND) && !router_full;
    assign last_flit = (flit_idx == IDX_W'(FLITS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Popping the next packet on the last-flit transfer keeps back-to-back
    // packets gapless.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (xfer && last_flit) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            flit_idx  <= '0;
        end else if (fifo_pop) begin
            shift_reg <= fifo_head;
            flit_idx  <= '0;
        end else if (xfer) begin
            shift_reg <= shift_reg << FLIT_SIZE;
            flit_idx  <= flit_idx + IDX_W'(1);
        end
    end

    always_comb begin
        write_req = (state == SEND);
        busy      = (state == SEND);
        flit_out  = (state == SEND) ? shift_reg[PACKET_SIZE-1 -: FLIT_SIZE] : '0;
    end

endmodule

// File: tb/tb_spike_inject_port.sv
// tb_spike_inject_port
// Directed scenarios plus a randomized run compared against a queue-based
// model of the injector. A second instance with a 2-bit drop counter shares
// all inputs so counter saturation can be observed.
module tb_spike_inject_port;

    localparam int NSRC  = 2;
    localparam int PK    = 32;
    localparam int FL    = 4;
    localparam int DEPTH = 4;
    localparam int FLITS = PK / FL;

    logic               clk = 1'b0;
    logic               reset;
    logic [NSRC-1:0]    spike_valid;
    logic [NSRC*PK-1:0] spike_packet;
    logic               router_full;
    logic [FL-1:0]      flit_out;
    logic               write_req;
    logic               busy;
    logic [2:0]         fifo_count;
    logic [NSRC-1:0]    src_pending;
    logic [7:0]         drop_count;

    logic [FL-1:0]      s_flit_out;
    logic               s_write_req;
    logic               s_busy;
    logic [2:0]         s_fifo_count;
    logic [NSRC-1:0]    s_src_pending;
    logic [1:0]         s_drop_count;

    int checks;
    int errors;

    // Reference model state: holders, packet queue, remaining flits of the
    // packet in flight, and total drops since reset.
    logic [PK-1:0]   m_hold [NSRC];
    bit   [NSRC-1:0] m_hold_v;
    int              m_rr;
    logic [PK-1:0]   m_fifo [$];
    logic [FL-1:0]   m_flits [$];
    int              m_drops;

    always #5 clk = ~clk;

    spike_inject_port #(
        .NUM_SRC(NSRC), .PACKET_SIZE(PK), .FLIT_SIZE(FL),
        .FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .spike_valid(spike_valid),
        .spike_packet(spike_packet), .router_full(router_full),
        .flit_out(flit_out), .write_req(write_req), .busy(busy),
        .fifo_count(fifo_count), .src_pending(src_pending),
        .drop_count(drop_count)
    );

    spike_inject_port #(
        .NUM_SRC(NSRC), .PACKET_SIZE(PK), .FLIT_SIZE(FL),
        .FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(2)
    ) dut_sat (
        .clk(clk), .reset(reset), .spike_valid(spike_valid),
        .spike_packet(spike_packet), .router_full(router_full),
        .flit_out(s_flit_out), .write_req(s_write_req), .busy(s_busy),
        .fifo_count(s_fifo_count), .src_pending(s_src_pending),
        .drop_count(s_drop_count)
    );

    task automatic model_step();
        int   g;
        bit   xfer;
        bit   do_pop;
        logic [PK-1:0] popped;
        if (reset) begin
            m_hold_v = '0;
            m_rr     = 0;
            m_drops  = 0;
            m_fifo.delete();
            m_flits.delete();
        end else begin
            g = -1;
            if (m_fifo.size() < DEPTH) begin
                for (int k = 0; k < NSRC; k++) begin
                    if (g < 0 && m_hold_v[(m_rr + k) % NSRC]) g = (m_rr + k) % NSRC;
                end
            end
            xfer   = (m_flits.size() > 0) && !router_full;
            do_pop = (m_fifo.size() > 0) && ((m_flits.size() == 0) || (xfer && m_flits.size() == 1));
            if (xfer) void'(m_flits.pop_front());
            if (do_pop) begin
                popped = m_fifo.pop_front();
                for (int k = 0; k < FLITS; k++) m_flits.push_back(popped[PK-1-FL*k -: FL]);
            end
            if (g >= 0) begin
                m_fifo.push_back(m_hold[g]);
                m_hold_v[g] = 1'b0;
                m_rr = (g + 1) % NSRC;
            end
            for (int i = 0; i < NSRC; i++) begin
                if (spike_valid[i]) begin
                    if (!m_hold_v[i]) begin
                        m_hold_v[i] = 1'b1;
                        m_hold[i]   = spike_packet[i*PK +: PK];
                    end else begin
                        m_drops++;
                    end
                end
            end
        end
    endtask

    // Advance one clock; the model sees the same pre-edge inputs as the DUT
    // and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic reset_dut();
        reset       = 1'b1;
        spike_valid = '0;
        router_full = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        spike_valid  = 2'b11;
        spike_packet = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        router_full  = 1'b0;
        tick();
        tick();
        spike_valid = '0;
        tick();
        reset = 1'b0;
        checks++; if (write_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_write_req got %b want 0", write_req); end
        checks++; if (flit_out !== 4'h0) begin errors++; $display("[TB] FAIL reset_flit_out got %h want 0", flit_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_fifo_count got %0d want 0", fifo_count); end
        checks++; if (src_pending !== 2'b00) begin errors++; $display("[TB] FAIL reset_src_pending got %b want 00", src_pending); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_drop_count got %0d want 0", drop_count); end
    endtask

    task automatic test_single_spike();
        logic [PK-1:0] pkt;
        pkt = 32'hA5C3_0F19;
        reset_dut();
        spike_packet = {32'h0, pkt};
        spike_valid  = 2'b01;
        tick();
        spike_valid = '0;
        checks++; if (src_pending !== 2'b01) begin errors++; $display("[TB] FAIL single_pending got %b want 01", src_pending); end
        tick();
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL single_fifo_count got %0d want 1", fifo_count); end
        tick();
        for (int k = 0; k < FLITS; k++) begin
            checks++;
            if (write_req !== 1'b1 || flit_out !== pkt[PK-1-FL*k -: FL]) begin
                errors++; $display("[TB] FAIL single_flit%0d got wr=%b flit=%h want wr=1 flit=%h", k, write_req, flit_out, pkt[PK-1-FL*k -: FL]);
            end
            tick();
        end
        checks++; if (write_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle got wr=%b busy=%b want 0 0", write_req, busy); end
    endtask

    task automatic test_simultaneous();
        logic [2*PK-1:0] stream;
        int w;
        reset_dut();
        stream       = {32'h1111_1111, 32'h2222_2222};
        spike_packet = {32'h2222_2222, 32'h1111_1111};
        spike_valid  = 2'b11;
        tick();
        spike_valid = '0;
        w = 0;
        while (write_req !== 1'b1 && w < 20) begin tick(); w++; end
        checks++; if (w != 2) begin errors++; $display("[TB] FAIL simul_start got %0d extra cycles want 2", w); end
        for (int k = 0; k < 2*FLITS; k++) begin
            checks++;
            if (write_req !== 1'b1 || flit_out !== stream[2*PK-1-FL*k -: FL]) begin
                errors++; $display("[TB] FAIL simul_flit%0d got wr=%b flit=%h want wr=1 flit=%h", k, write_req, flit_out, stream[2*PK-1-FL*k -: FL]);
            end
            tick();
        end
        checks++; if (write_req !== 1'b0) begin errors++; $display("[TB] FAIL simul_end got wr=%b want 0", write_req); end
        // Pointer back at source 0: a second simultaneous pair starts with src0.
        spike_packet = {32'h4444_4444, 32'h3333_3333};
        spike_valid  = 2'b11;
        tick();
        spike_valid = '0;
        w = 0;
        while (write_req !== 1'b1 && w < 20) begin tick(); w++; end
        checks++; if (write_req !== 1'b1 || flit_out !== 4'h3) begin errors++; $display("[TB] FAIL simul_rr_first got wr=%b flit=%h want wr=1 flit=3", write_req, flit_out); end
        repeat (FLITS) tick();
        checks++; if (write_req !== 1'b1 || flit_out !== 4'h4) begin errors++; $display("[TB] FAIL simul_rr_second got wr=%b flit=%h want wr=1 flit=4", write_req, flit_out); end
    endtask

    task automatic test_backpressure();
        logic [PK-1:0] pkt;
        int w;
        pkt = 32'h1234_5678;
        reset_dut();
        spike_packet = {32'h0, pkt};
        spike_valid  = 2'b01;
        tick();
        spike_valid = '0;
        w = 0;
        while (write_req !== 1'b1 && w < 20) begin tick(); w++; end
        for (int k = 0; k < FLITS; k++) begin
            checks++;
            if (write_req !== 1'b1 || flit_out !== pkt[PK-1-FL*k -: FL]) begin
                errors++; $display("[TB] FAIL bp_flit%0d got wr=%b flit=%h want wr=1 flit=%h", k, write_req, flit_out, pkt[PK-1-FL*k -: FL]);
            end
            if (k == 3) begin
                router_full = 1'b1;
                for (int h = 0; h < 5; h++) begin
                    tick();
                    checks++;
                    if (write_req !== 1'b1 || flit_out !== 4'h4) begin
                        errors++; $display("[TB] FAIL bp_hold%0d got wr=%b flit=%h want wr=1 flit=4", h, write_req, flit_out);
                    end
                end
                router_full = 1'b0;
            end
            tick();
        end
        checks++; if (write_req !== 1'b0) begin errors++; $display("[TB] FAIL bp_end got wr=%b want 0", write_req); end
    endtask

    task automatic test_overflow();
        int w;
        reset_dut();
        router_full  = 1'b1;
        spike_packet = {32'h0, 32'hDEAD_0000};
        spike_valid  = 2'b01;
        tick();
        spike_valid = '0;
        w = 0;
        while (busy !== 1'b1 && w < 20) begin tick(); w++; end
        for (int k = 0; k < 7; k++) begin
            spike_packet = {32'h0, 32'hBEEF_0000 + k};
            spike_valid  = 2'b01;
            tick();
        end
        spike_valid = '0;
        tick();
        tick();
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL ovf_fifo_count got %0d want 4", fifo_count); end
        checks++; if (src_pending !== 2'b01) begin errors++; $display("[TB] FAIL ovf_pending got %b want 01", src_pending); end
        checks++; if (drop_count !== 8'd2) begin errors++; $display("[TB] FAIL ovf_drop_count got %0d want 2", drop_count); end
        checks++; if (s_drop_count !== 2'd2) begin errors++; $display("[TB] FAIL ovf_sat_drop got %0d want 2", s_drop_count); end
        checks++; if (write_req !== 1'b1 || flit_out !== 4'hD) begin errors++; $display("[TB] FAIL ovf_hold got wr=%b flit=%h want wr=1 flit=d", write_req, flit_out); end
    endtask

    // Continues from the stalled overflow state: every further spike drops.
    task automatic test_drop_saturation();
        for (int k = 0; k < 4; k++) begin
            spike_packet = {32'h0, 32'hCCCC_0000 + k};
            spike_valid  = 2'b01;
            tick();
        end
        spike_valid = '0;
        tick();
        checks++; if (drop_count !== 8'd6) begin errors++; $display("[TB] FAIL sat_wide_drop got %0d want 6", drop_count); end
        checks++; if (s_drop_count !== 2'd3) begin errors++; $display("[TB] FAIL sat_narrow_drop got %0d want 3", s_drop_count); end
        router_full = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        logic [PK-1:0] pkt;
        int w;
        reset_dut();
        spike_packet = {32'h0123_4567, 32'hCAFE_BABE};
        spike_valid  = 2'b11;
        tick();
        spike_valid = '0;
        w = 0;
        while (write_req !== 1'b1 && w < 20) begin tick(); w++; end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        checks++; if (write_req !== 1'b0 || fifo_count !== 3'd0 || src_pending !== 2'b00) begin
            errors++; $display("[TB] FAIL midrst_clear got wr=%b cnt=%0d pend=%b want 0 0 00", write_req, fifo_count, src_pending);
        end
        reset = 1'b0;
        pkt = 32'h9ABC_DEF0;
        spike_packet = {pkt, 32'h0};
        spike_valid  = 2'b10;
        tick();
        spike_valid = '0;
        w = 0;
        while (write_req !== 1'b1 && w < 20) begin tick(); w++; end
        for (int k = 0; k < FLITS; k++) begin
            checks++;
            if (write_req !== 1'b1 || flit_out !== pkt[PK-1-FL*k -: FL]) begin
                errors++; $display("[TB] FAIL midrst_flit%0d got wr=%b flit=%h want wr=1 flit=%h", k, write_req, flit_out, pkt[PK-1-FL*k -: FL]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic          exp_wr;
        logic [FL-1:0] exp_flit;
        logic [2:0]    exp_cnt;
        logic [7:0]    exp_drop;
        logic [1:0]    exp_sdrop;
        reset_dut();
        for (int c = 0; c < 1500; c++) begin
            reset        = ($urandom_range(0, 399) == 0);
            spike_valid  = {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3)};
            spike_packet = {$urandom(), $urandom()};
            router_full  = ($urandom_range(0, 3) == 0);
            tick();
            exp_wr    = (m_flits.size() > 0);
            exp_flit  = exp_wr ? m_flits[0] : '0;
            exp_cnt   = 3'(m_fifo.size());
            exp_drop  = (m_drops > 255) ? 8'd255 : 8'(m_drops);
            exp_sdrop = (m_drops > 3) ? 2'd3 : 2'(m_drops);
            checks++;
            if (write_req !== exp_wr || busy !== exp_wr || flit_out !== exp_flit || fifo_count !== exp_cnt ||
                src_pending !== m_hold_v || drop_count !== exp_drop || s_drop_count !== exp_sdrop) begin
                errors++;
                $display("[TB] FAIL random_c%0d got wr=%b busy=%b flit=%h cnt=%0d pend=%b drop=%0d sdrop=%0d want wr=%b flit=%h cnt=%0d pend=%b drop=%0d sdrop=%0d",
                         c, write_req, busy, flit_out, fifo_count, src_pending, drop_count, s_drop_count,
                         exp_wr, exp_flit, exp_cnt, m_hold_v, exp_drop, exp_sdrop);
            end
        end
        reset       = 1'b0;
        spike_valid = '0;
        router_full = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        spike_valid  = '0;
        spike_packet = '0;
        router_full  = 1'b0;
        m_hold_v     = '0;
        m_rr         = 0;
        m_drops      = 0;
        test_reset();
        test_single_spike();
        test_simultaneous();
        test_backpressure();
        test_overflow();
        test_drop_saturation();
        test_reset_mid_packet();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
